// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among functional units,
// with a registered one-cycle broadcast of the winner's result.
module cdb_arbiter #(
    parameter int NUM_FU = 4,
    parameter int TAG_W  = 5,
    parameter int XLEN   = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       squash,
    input  logic                       cdb_stall,
    input  logic [NUM_FU-1:0]          fu_done,
    input  logic [NUM_FU*TAG_W-1:0]    fu_rob_tag,
    input  logic [NUM_FU*XLEN-1:0]     fu_value,
    input  logic [NUM_FU-1:0]          fu_take_branch,
    input  logic [NUM_FU-1:0]          fu_mispredicted,
    output logic [NUM_FU-1:0]          fu_ack,
    output logic                       cdb_valid,
    output logic [TAG_W-1:0]           cdb_rob_tag,
    output logic [XLEN-1:0]            cdb_value,
    output logic                       cdb_take_branch,
    output logic                       cdb_mispredicted,
    output logic [$clog2(NUM_FU)-1:0]  grant_ptr
);

    localparam int PW = $clog2(NUM_FU);
    localparam int IW = PW + 1;

    logic [IW-1:0]    idx;
    logic [PW-1:0]    win;
    logic [PW-1:0]    next_ptr;
    logic             found;
    logic             grant;
    logic [TAG_W-1:0] sel_tag;
    logic [XLEN-1:0]  sel_value;
    logic             sel_take;
    logic             sel_misp;

    // Search ascending from grant_ptr; the extra index bit lets the
    // wrap work for non-power-of-two NUM_FU.
    always_comb begin
        idx   = '0;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = {1'b0, grant_ptr} + IW'(k);
            if (idx >= IW'(NUM_FU))
                idx = idx - IW'(NUM_FU);
            if (!found && fu_done[idx[PW-1:0]]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
    end

    assign grant = found & ~squash & ~cdb_stall & reset;

    always_comb begin
        fu_ack    = '0;
        sel_tag   = '0;
        sel_value = '0;
        sel_take  = 1'b0;
        sel_misp  = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (grant && win == PW'(i))
                fu_ack[i] = 1'b1;
        end
        // One-hot AND-OR mux keeps idle FUs' fields out of the result.
        for (int i = 0; i < NUM_FU; i++) begin
            if (fu_ack[i]) begin
                sel_tag   = fu_rob_tag[i*TAG_W +: TAG_W];
                sel_value = fu_value[i*XLEN +: XLEN];
                sel_take  = fu_take_branch[i];
                sel_misp  = fu_mispredicted[i];
            end
        end
    end

    assign next_ptr = (win == PW'(NUM_FU - 1)) ? '0 : win + PW'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cdb_valid        <= 1'b0;
            cdb_rob_tag      <= '0;
            cdb_value        <= '0;
            cdb_take_branch  <= 1'b0;
            cdb_mispredicted <= 1'b0;
            grant_ptr        <= '0;
        end else if (squash) begin
            cdb_valid <= 1'b0;
        end else if (cdb_stall) begin
            cdb_valid <= cdb_valid;
        end else if (grant) begin
            cdb_valid        <= 1'b1;
            cdb_rob_tag      <= sel_tag;
            cdb_value        <= sel_value;
            cdb_take_branch  <= sel_take;
            cdb_mispredicted <= sel_misp;
            grant_ptr        <= next_ptr;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed vector bench for cdb_arbiter (NUM_FU=4, TAG_W=5, XLEN=32).
module tb_cdb_arbiter;

    logic        clock;
    logic        reset;
    logic        squash;
    logic        cdb_stall;
    logic [3:0]  fu_done;
    logic [19:0] fu_rob_tag;
    logic [127:0] fu_value;
    logic [3:0]  fu_take_branch;
    logic [3:0]  fu_mispredicted;
    logic [3:0]  fu_ack;
    logic        cdb_valid;
    logic [4:0]  cdb_rob_tag;
    logic [31:0] cdb_value;
    logic        cdb_take_branch;
    logic        cdb_mispredicted;
    logic [1:0]  grant_ptr;

    cdb_arbiter #(.NUM_FU(4), .TAG_W(5), .XLEN(32)) dut (
        .clock            (clock),
        .reset            (reset),
        .squash           (squash),
        .cdb_stall        (cdb_stall),
        .fu_done          (fu_done),
        .fu_rob_tag       (fu_rob_tag),
        .fu_value         (fu_value),
        .fu_take_branch   (fu_take_branch),
        .fu_mispredicted  (fu_mispredicted),
        .fu_ack           (fu_ack),
        .cdb_valid        (cdb_valid),
        .cdb_rob_tag      (cdb_rob_tag),
        .cdb_value        (cdb_value),
        .cdb_take_branch  (cdb_take_branch),
        .cdb_mispredicted (cdb_mispredicted),
        .grant_ptr        (grant_ptr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       sq;
        logic       st;
        logic [3:0] done;
        logic [3:0] ack;
        logic       valid;
        logic [4:0] tag;
        logic [1:0] ptr;
    } vec_t;

    vec_t vt[19];
    int   n_vec = 0;
    int   n_bad = 0;

    logic [31:0] m_val;
    logic        m_take;
    logic        m_misp;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] val_of(input int i, input int k);
        return 32'h1000_0000 * (i + 1) + 32'(k);
    endfunction

    task automatic set_values(input int k);
        for (int i = 0; i < 4; i++)
            fu_value[i*32 +: 32] = val_of(i, k);
    endtask

    initial begin
        // FU tags: FU0=12, FU1=3, FU2=7, FU3=20
        vt[0]  = '{0,0,4'b0110,4'b0010,1,5'd3, 2'd2};
        vt[1]  = '{0,0,4'b0000,4'b0000,0,5'd3, 2'd2};
        vt[2]  = '{0,0,4'b1111,4'b0100,1,5'd7, 2'd3};
        vt[3]  = '{0,0,4'b1111,4'b1000,1,5'd20,2'd0};
        vt[4]  = '{0,0,4'b1111,4'b0001,1,5'd12,2'd1};
        vt[5]  = '{0,0,4'b1111,4'b0010,1,5'd3, 2'd2};
        vt[6]  = '{0,0,4'b1111,4'b0100,1,5'd7, 2'd3};
        vt[7]  = '{0,0,4'b1111,4'b1000,1,5'd20,2'd0};
        vt[8]  = '{0,0,4'b0100,4'b0100,1,5'd7, 2'd3};
        vt[9]  = '{0,0,4'b1001,4'b1000,1,5'd20,2'd0};
        vt[10] = '{0,0,4'b0001,4'b0001,1,5'd12,2'd1};
        vt[11] = '{0,1,4'b0001,4'b0000,1,5'd12,2'd1};
        vt[12] = '{0,1,4'b0001,4'b0000,1,5'd12,2'd1};
        vt[13] = '{0,0,4'b0001,4'b0001,1,5'd12,2'd1};
        vt[14] = '{1,0,4'b0100,4'b0000,0,5'd12,2'd1};
        vt[15] = '{1,1,4'b0100,4'b0000,0,5'd12,2'd1};
        vt[16] = '{0,0,4'b0100,4'b0100,1,5'd7, 2'd3};
        vt[17] = '{0,0,4'b1010,4'b1000,1,5'd20,2'd0};
        vt[18] = '{0,0,4'b0010,4'b0010,1,5'd3, 2'd2};

        reset           = 1'b0;
        squash          = 1'b0;
        cdb_stall       = 1'b0;
        fu_done         = 4'b1111;
        fu_rob_tag      = {5'd20, 5'd7, 5'd3, 5'd12};
        fu_take_branch  = 4'b0101;
        fu_mispredicted = 4'b0011;
        set_values(99);
        m_val  = '0;
        m_take = 1'b0;
        m_misp = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_ack",   32'(fu_ack),      0);
        chk("rst_valid", 32'(cdb_valid),   0);
        chk("rst_tag",   32'(cdb_rob_tag), 0);
        chk("rst_value", cdb_value,        0);
        chk("rst_ptr",   32'(grant_ptr),   0);

        @(negedge clock);
        reset   = 1'b1;
        fu_done = 4'b0000;

        for (int k = 0; k < 19; k++) begin
            @(negedge clock);
            squash    = vt[k].sq;
            cdb_stall = vt[k].st;
            fu_done   = vt[k].done;
            set_values(k);
            #1;
            chk($sformatf("v%0d_ack", k), 32'(fu_ack), 32'(vt[k].ack));
            for (int i = 0; i < 4; i++) begin
                if (vt[k].ack[i]) begin
                    m_val  = val_of(i, k);
                    m_take = fu_take_branch[i];
                    m_misp = fu_mispredicted[i];
                end
            end
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_valid", k), 32'(cdb_valid), 32'(vt[k].valid));
            chk($sformatf("v%0d_tag", k), 32'(cdb_rob_tag), 32'(vt[k].tag));
            chk($sformatf("v%0d_ptr", k), 32'(grant_ptr), 32'(vt[k].ptr));
            chk($sformatf("v%0d_value", k), cdb_value, m_val);
            chk($sformatf("v%0d_br", k),
                32'({cdb_take_branch, cdb_mispredicted}), 32'({m_take, m_misp}));
        end

        // Asynchronous reset mid-cycle while a broadcast is live
        #2;
        fu_done = 4'b1000;
        reset   = 1'b0;
        #1;
        chk("arst_valid", 32'(cdb_valid),   0);
        chk("arst_tag",   32'(cdb_rob_tag), 0);
        chk("arst_value", cdb_value,        0);
        chk("arst_ptr",   32'(grant_ptr),   0);
        chk("arst_ack",   32'(fu_ack),      0);

        @(negedge clock);
        reset = 1'b1;
        set_values(50);
        #1;
        chk("post_ack", 32'(fu_ack), 32'(4'b1000));
        @(posedge clock);
        #1;
        chk("post_valid", 32'(cdb_valid),   1);
        chk("post_tag",   32'(cdb_rob_tag), 20);
        chk("post_value", cdb_value,        val_of(3, 50));
        chk("post_ptr",   32'(grant_ptr),   0);

        @(negedge clock);
        fu_done = 4'b0000;
        @(posedge clock);
        #1;
        chk("idle_valid", 32'(cdb_valid), 0);
        chk("idle_tag",   32'(cdb_rob_tag), 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter: NUM_FU, default 4, number of functional-unit requesters (2..8).
REQ-002 Parameter: TAG_W, default 5, ROB tag width.
REQ-003 Parameter: XLEN, default 32, result width.
REQ-004 Port: clock  in  1  single clock; all state updates on rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-low reset.
REQ-006 Port: squash  in  1  pipeline flush; suppresses grants, clears broadcast.
REQ-007 Port: cdb_stall  in  1  downstream cannot accept a broadcast this cycle.
REQ-008 Port: fu_done  in  NUM_FU  per-FU result-ready request.
REQ-009 Port: fu_rob_tag  in  NUM_FU*TAG_W  per-FU ROB tag; FU i in bits [i*TAG_W +: TAG_W].
REQ-010 Port: fu_value  in  NUM_FU*XLEN  per-FU result; FU i in bits [i*XLEN +: XLEN].
REQ-011 Port: fu_take_branch  in  NUM_FU  per-FU resolved branch taken.
REQ-012 Port: fu_mispredicted  in  NUM_FU  per-FU misprediction flag.
REQ-013 Port: fu_ack  out  NUM_FU  one-hot grant/ack to FU; combinational.
REQ-014 Port: cdb_valid  out  1  registered broadcast valid.
REQ-015 Port: cdb_rob_tag  out  TAG_W  registered broadcast tag.
REQ-016 Port: cdb_value  out  XLEN  registered broadcast value.
REQ-017 Port: cdb_take_branch  out  1  registered broadcast branch-taken.
REQ-018 Port: cdb_mispredicted  out  1  registered broadcast mispredict.
REQ-019 Port: grant_ptr  out  $clog2(NUM_FU)  current round-robin priority pointer, debug.

Function
REQ-020 fu_ack SHALL be zero or one-hot, never multi-hot.
REQ-021 Grant condition: fu_done nonzero, squash=0, cdb_stall=0.
REQ-022 Winner SHALL be the first requester with fu_done set, searching ascending from grant_ptr and wrapping mod NUM_FU.
REQ-023 fu_ack[i] SHALL assert combinationally in the same cycle as the winning fu_done[i]; the FU releases its register on that edge.
REQ-024 On a grant edge, the cdb_* registers SHALL load the winner's tag, value, take_branch and mispredicted, and cdb_valid SHALL be 1: one-cycle latency from grant to broadcast.
REQ-025 On a grant edge, grant_ptr SHALL become (winner+1) mod NUM_FU; wrap from NUM_FU-1 to 0.
REQ-026 With no grant and no stall, cdb_valid SHALL go 0 next edge; other cdb_* fields hold.
REQ-027 With cdb_stall=1 and squash=0, all cdb_* registers and grant_ptr SHALL hold; fu_ack=0.
REQ-028 With squash=1, whatever cdb_stall is: fu_ack=0; cdb_valid cleared next edge; grant_ptr holds.
REQ-029 Non-granted requesters SHALL keep fu_done asserted; no request is dropped or reordered within an FU.
REQ-030 Fairness: a continuously requesting FU SHALL be granted within NUM_FU grant cycles.
REQ-031 Tag/value fields of non-requesting FUs SHALL NOT affect any output.

Reset
REQ-032 On reset=0, asynchronously: cdb_valid=0, cdb_rob_tag=0, cdb_value=0, cdb_take_branch=0, cdb_mispredicted=0, grant_ptr=0.
REQ-033 While reset=0, fu_ack SHALL be 0.
REQ-034 Reset asserted mid-operation SHALL discard any pending broadcast; the first grant after release starts search at FU 0.

Verification
REQ-035 After reset, fu_done=4'b0110, tags 3/7 on FU1/FU2 -> fu_ack=4'b0010; next cycle cdb_valid=1, cdb_rob_tag=3, grant_ptr=2.
REQ-036 fu_done=4'b1111 held 4 cycles, ack honoured -> grants FU0,FU1,FU2,FU3 in order; grant_ptr wraps to 0.
REQ-037 grant_ptr=3, fu_done=4'b1001 -> FU3 granted, then FU0; grant_ptr 0 then 1.
REQ-038 cdb_stall=1 for 2 cycles, fu_done=4'b0001 -> fu_ack=0, cdb_* hold; stall drops -> FU0 acked, broadcast next cycle.
REQ-039 squash=1 with cdb_valid=1, fu_done=4'b0100 -> fu_ack=0, cdb_valid=0 next edge, grant_ptr unchanged.
REQ-040 reset asserted asynchronously between edges while cdb_valid=1 -> cdb_valid=0 immediately; after release fu_done=4'b1000 -> FU3 granted, grant_ptr=0.
